// File: rtl/uart_rx.sv
// UART receiver: 2-flop rxd synchronizer, start-edge detect, mid-bit sampling
// driven by an external OVERSAMPLE x baud tick, and a one-deep holding register.
module uart_rx #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rxd,
   input  logic                 baud_tick,
   input  logic                 rx_read,
   output logic                 receive_start,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 framing_error,
   output logic                 overrun,
   output logic                 rx_busy
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] T_ONE  = TW'(1);
   localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] B_ONE  = BW'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_e;

   state_e                 state_q, state_d;
   logic                   sync1_q, sync2_q, prev_q;
   logic [TW-1:0]          tcnt_q, tcnt_d;
   logic [BW-1:0]          bcnt_q, bcnt_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic [DATA_BITS-1:0]   data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   fe_q, fe_d;
   logic                   ovr_q, ovr_d;
   logic                   start_q, start_d;
   logic                   busy_q;
   logic                   fall_s, done_ok_s, done_fe_s;

   assign fall_s = prev_q & ~sync2_q;

   // Synchronizer and edge-detect flops; idle-high reset avoids a false start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= rxd;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state, tick/bit counting and data shifting
   always_comb begin
      state_d   = state_q;
      tcnt_d    = tcnt_q;
      bcnt_d    = bcnt_q;
      shift_d   = shift_q;
      start_d   = 1'b0;
      done_ok_s = 1'b0;
      done_fe_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (fall_s) begin
               start_d = 1'b1;
               tcnt_d  = '0;
               state_d = START;
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            if (baud_tick) begin
               if (tcnt_q == T_MID) begin
                  // a high sample at mid start bit is a glitch, not a frame
                  if (!sync2_q) begin
                     tcnt_d  = '0;
                     bcnt_d  = '0;
                     state_d = DATA;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  tcnt_d = tcnt_q + T_ONE;
               end
            end else begin
               tcnt_d = tcnt_q;
            end
         end
         DATA: begin
            if (baud_tick) begin
               if (tcnt_q == T_END) begin
                  shift_d = {sync2_q, shift_q[DATA_BITS-1:1]};
                  tcnt_d  = '0;
                  bcnt_d  = bcnt_q + B_ONE;
                  if (bcnt_q == B_LAST) begin
                     state_d = STOP;
                  end else begin
                     state_d = DATA;
                  end
               end else begin
                  tcnt_d = tcnt_q + T_ONE;
               end
            end else begin
               tcnt_d = tcnt_q;
            end
         end
         STOP: begin
            if (baud_tick) begin
               if (tcnt_q == T_END) begin
                  tcnt_d  = '0;
                  state_d = IDLE;
                  if (sync2_q) begin
                     done_ok_s = 1'b1;
                  end else begin
                     done_fe_s = 1'b1;
                  end
               end else begin
                  tcnt_d = tcnt_q + T_ONE;
               end
            end else begin
               tcnt_d = tcnt_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Holding register and flags; a completion in the same cycle as rx_read wins
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      fe_d    = fe_q;
      ovr_d   = ovr_q;
      if (done_ok_s) begin
         data_d  = shift_q;
         valid_d = 1'b1;
         fe_d    = rx_read ? 1'b0 : fe_q;
         ovr_d   = rx_read ? 1'b0 : (ovr_q | valid_q);
      end else if (done_fe_s) begin
         fe_d    = 1'b1;
         valid_d = rx_read ? 1'b0 : valid_q;
         ovr_d   = rx_read ? 1'b0 : ovr_q;
      end else if (rx_read) begin
         valid_d = 1'b0;
         fe_d    = 1'b0;
         ovr_d   = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // Datapath registers and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tcnt_q  <= '0;
         bcnt_q  <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         fe_q    <= 1'b0;
         ovr_q   <= 1'b0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         tcnt_q  <= tcnt_d;
         bcnt_q  <= bcnt_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         fe_q    <= fe_d;
         ovr_q   <= ovr_d;
         start_q <= start_d;
         busy_q  <= (state_d != IDLE);
      end
   end

   assign receive_start = start_q;
   assign rx_data       = data_q;
   assign rx_valid      = valid_q;
   assign framing_error = fe_q;
   assign overrun       = ovr_q;
   assign rx_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus queues expected frame results, a
// monitor checks them each time rx_busy falls at the end of a frame.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rxd;
   logic       baud_tick;
   logic       rx_read;
   logic       rx_read_stim;
   logic       rx_read_done;
   logic       receive_start;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       framing_error;
   logic       overrun;
   logic       rx_busy;

   typedef struct {
      logic [7:0] data;
      logic       valid;
      logic       fe;
      logic       ovr;
      int         ticks;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   tick_cnt = 0;
   bit   read_at_done = 1'b0;
   bit   mon_en = 1'b0;

   assign rx_read = rx_read_stim | rx_read_done;

   uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rxd           (rxd),
      .baud_tick     (baud_tick),
      .rx_read       (rx_read),
      .receive_start (receive_start),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .framing_error (framing_error),
      .overrun       (overrun),
      .rx_busy       (rx_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Tick generator (every 4 clk); counts ticks consumed since the start pulse
   initial begin
      int phase;
      phase = 0;
      baud_tick = 1'b0;
      rx_read_done = 1'b0;
      forever begin
         @(negedge clk);
         if (receive_start) tick_cnt = 0;
         phase = (phase + 1) % 4;
         baud_tick = (phase == 0);
         rx_read_done = read_at_done && baud_tick && rx_busy && (tick_cnt == 151);
         if (baud_tick && rx_busy) tick_cnt++;
      end
   end

   // Monitor: pops one expectation per frame end
   initial begin
      bit   prev_busy;
      int   starts;
      exp_t e;
      prev_busy = 1'b0;
      starts = 0;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            starts = 0;
         end else begin
            if (receive_start) starts++;
            if (prev_busy && !rx_busy) begin
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_frame_end: got frame end, expected none");
               end else begin
                  e = exp_q.pop_front();
                  check("frame_data",  32'(rx_data),       32'(e.data));
                  check("frame_valid", 32'(rx_valid),      32'(e.valid));
                  check("frame_fe",    32'(framing_error), 32'(e.fe));
                  check("frame_ovr",   32'(overrun),       32'(e.ovr));
                  check("frame_ticks", 32'(tick_cnt),      32'(e.ticks));
                  check("frame_starts", 32'(starts),       32'd1);
               end
               starts = 0;
            end
         end
         prev_busy = rx_busy;
      end
   end

   task automatic expect_frame(input logic [7:0] d, input logic v, input logic fe,
                               input logic ovr, input int ticks);
      exp_t e;
      e.data = d; e.valid = v; e.fe = fe; e.ovr = ovr; e.ticks = ticks;
      exp_q.push_back(e);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      rxd = 1'b0;
      repeat (64) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (64) @(negedge clk);
      end
      rxd = stop;
      repeat (64) @(negedge clk);
      rxd = 1'b1;
      repeat (32) @(negedge clk);
   endtask

   task automatic read_and_check(input logic [7:0] d);
      rx_read_stim = 1'b1;
      @(negedge clk);
      rx_read_stim = 1'b0;
      check("read_valid", 32'(rx_valid),      32'd0);
      check("read_fe",    32'(framing_error), 32'd0);
      check("read_ovr",   32'(overrun),       32'd0);
      check("read_data",  32'(rx_data),       32'(d));
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      rxd = 1'b1;
      rx_read_stim = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_start", 32'(receive_start), 32'd0);
      check("rst_data",  32'(rx_data),       32'd0);
      check("rst_valid", 32'(rx_valid),      32'd0);
      check("rst_fe",    32'(framing_error), 32'd0);
      check("rst_ovr",   32'(overrun),       32'd0);
      check("rst_busy",  32'(rx_busy),       32'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      mon_en = 1'b1;

      expect_frame(8'hA5, 1'b1, 1'b0, 1'b0, 152);
      send_byte(8'hA5, 1'b1);
      check("a5_busy_idle", 32'(rx_busy), 32'd0);
      read_and_check(8'hA5);

      expect_frame(8'h3C, 1'b1, 1'b0, 1'b0, 152);
      send_byte(8'h3C, 1'b1);
      expect_frame(8'h81, 1'b1, 1'b0, 1'b1, 152);
      send_byte(8'h81, 1'b1);
      read_and_check(8'h81);

      expect_frame(8'h81, 1'b0, 1'b1, 1'b0, 152);
      send_byte(8'h55, 1'b0);
      read_and_check(8'h81);

      expect_frame(8'h81, 1'b0, 1'b0, 1'b0, 8);
      rxd = 1'b0;
      repeat (12) @(negedge clk);
      rxd = 1'b1;
      repeat (80) @(negedge clk);
      expect_frame(8'h0F, 1'b1, 1'b0, 1'b0, 152);
      send_byte(8'h0F, 1'b1);
      read_and_check(8'h0F);

      expect_frame(8'h11, 1'b1, 1'b0, 1'b0, 152);
      send_byte(8'h11, 1'b1);
      read_at_done = 1'b1;
      expect_frame(8'h22, 1'b1, 1'b0, 1'b0, 152);
      send_byte(8'h22, 1'b1);
      read_at_done = 1'b0;
      check("rd_done_valid", 32'(rx_valid), 32'd1);
      check("rd_done_data",  32'(rx_data),  32'h22);
      check("rd_done_ovr",   32'(overrun),  32'd0);

      mon_en = 1'b0;
      rxd = 1'b0;
      repeat (64) @(negedge clk);
      rxd = 1'b0;
      repeat (4 * 64 + 32) @(negedge clk);
      rxd = 1'b1;
      check("pre_rst_busy", 32'(rx_busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("arst_data",  32'(rx_data),       32'd0);
      check("arst_valid", 32'(rx_valid),      32'd0);
      check("arst_fe",    32'(framing_error), 32'd0);
      check("arst_ovr",   32'(overrun),       32'd0);
      check("arst_busy",  32'(rx_busy),       32'd0);
      check("arst_start", 32'(receive_start), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (16) @(negedge clk);
      mon_en = 1'b1;
      expect_frame(8'hF0, 1'b1, 1'b0, 1'b0, 152);
      send_byte(8'hF0, 1'b1);

      repeat (16) @(negedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
